// File: rtl/spike_rate_encoder.sv
// Rate-to-spike encoder: each accepted rate word R produces one window of
// SPIKING_WINDOW cycles carrying min(R, SPIKING_WINDOW) evenly spaced
// single-cycle spikes on spike_out (pre_spike toward the synapse array).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no window in progress, ready for a rate word
//   ENCODE | window in progress; cyc_left counts down to the last cycle
module spike_rate_encoder #(
   parameter int SPIKING_WINDOW = 16,
   parameter int RATE_W         = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [RATE_W-1:0] in_rate,
   output logic              spike_out,
   output logic              window_start,
   output logic              window_done,
   output logic              busy,
   output logic              rate_sat
);

   localparam int ACC_W = $clog2(2 * SPIKING_WINDOW);
   localparam int CNT_W = $clog2(SPIKING_WINDOW);

   localparam logic [RATE_W-1:0] W_RATE   = RATE_W'(SPIKING_WINDOW);
   localparam logic [ACC_W-1:0]  W_ACC    = ACC_W'(SPIKING_WINDOW);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SPIKING_WINDOW - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      IDLE,
      ENCODE
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cyc_left, cyc_left_nxt;
   logic [ACC_W-1:0]   acc, acc_nxt;
   logic [ACC_W-1:0]   rate_r, rate_nxt;
   logic [ACC_W-1:0]   acc_sum;
   logic [RATE_W-1:0]  rate_clip;
   logic               last_cyc;
   logic               hs;
   logic               fire;
   logic               spike_nxt, start_nxt, done_nxt, busy_nxt, sat_nxt;

   // cyc_left == 0 marks window cycle k == SPIKING_WINDOW, where a new word may chain in
   assign last_cyc  = (state == ENCODE) && (cyc_left == '0);
   assign in_ready  = !rst && ((state == IDLE) || last_cyc);
   assign hs        = in_valid && in_ready;
   assign rate_clip = (in_rate > W_RATE) ? W_RATE : in_rate;

   // Next-state, accumulator and next-cycle output values
   always_comb begin
      state_nxt    = state;
      cyc_left_nxt = cyc_left;
      rate_nxt     = rate_r;
      acc_sum      = acc + rate_r;
      acc_nxt      = acc;
      fire         = 1'b0;
      spike_nxt    = 1'b0;
      start_nxt    = 1'b0;
      done_nxt     = 1'b0;
      busy_nxt     = 1'b0;
      sat_nxt      = 1'b0;

      if (hs) begin
         // Fresh window: the accumulator restarts from zero, so k=1 sees just R
         state_nxt    = ENCODE;
         cyc_left_nxt = CNT_LOAD;
         rate_nxt     = ACC_W'(rate_clip);
         acc_sum      = ACC_W'(rate_clip);
         start_nxt    = 1'b1;
         busy_nxt     = 1'b1;
         sat_nxt      = (in_rate > W_RATE);
      end else if ((state == ENCODE) && !last_cyc) begin
         cyc_left_nxt = cyc_left - CNT_ONE;
         busy_nxt     = 1'b1;
         done_nxt     = (cyc_left == CNT_ONE);
      end else if (last_cyc) begin
         state_nxt    = IDLE;
         cyc_left_nxt = '0;
      end

      // acc < W and R <= W, so acc_sum < 2W always fits in ACC_W bits
      if (busy_nxt) begin
         fire      = (acc_sum >= W_ACC);
         acc_nxt   = fire ? (acc_sum - W_ACC) : acc_sum;
         spike_nxt = fire;
      end else begin
         acc_nxt   = '0;
      end
   end

   // State, counter, accumulator and registered outputs; reset wins over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cyc_left     <= '0;
         acc          <= '0;
         rate_r       <= '0;
         spike_out    <= 1'b0;
         window_start <= 1'b0;
         window_done  <= 1'b0;
         busy         <= 1'b0;
         rate_sat     <= 1'b0;
      end else begin
         state        <= state_nxt;
         cyc_left     <= cyc_left_nxt;
         acc          <= acc_nxt;
         rate_r       <= rate_nxt;
         spike_out    <= spike_nxt;
         window_start <= start_nxt;
         window_done  <= done_nxt;
         busy         <= busy_nxt;
         rate_sat     <= sat_nxt;
      end
   end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: directed scenarios followed by random traffic,
// all checked cycle by cycle against a window-position reference model.
module tb_spike_rate_encoder;

   localparam int W  = 16;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [RW-1:0] in_rate;
   logic          spike_out;
   logic          window_start;
   logic          window_done;
   logic          busy;
   logic          rate_sat;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: current window position (0 = idle), clipped rate, sat flag
   int m_k   = 0;
   int m_r   = 0;
   bit m_sat = 1'b0;
   int win_spk = 0;
   int win_cnt = 0;

   always #5 clk = ~clk;

   spike_rate_encoder #(
      .SPIKING_WINDOW (W),
      .RATE_W         (RW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_rate      (in_rate),
      .spike_out    (spike_out),
      .window_start (window_start),
      .window_done  (window_done),
      .busy         (busy),
      .rate_sat     (rate_sat)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d expected %0d (k=%0d R=%0d)", tag, $time, got, exp, m_k, m_r);
      end
   endtask

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic bit exp_spike(input int k, input int r);
      return ((k * r) / W) > (((k - 1) * r) / W);
   endfunction

   // One clock: check outputs of the current cycle, drive inputs, check in_ready,
   // then advance the model to what the coming posedge should produce.
   task automatic step(input bit r_v, input bit v_v, input int rate_v, input bit cmp_out = 1'b1);
      bit exp_rdy;
      @(negedge clk);
      if (cmp_out) begin
         chk("busy",         32'(busy),         32'(m_k != 0));
         chk("window_start", 32'(window_start), 32'(m_k == 1));
         chk("window_done",  32'(window_done),  32'(m_k == W));
         chk("rate_sat",     32'(rate_sat),     32'((m_k == 1) && m_sat));
         chk("spike_out",    32'(spike_out),    32'((m_k != 0) && exp_spike(m_k, m_r)));
         if (m_k != 0) begin
            if (m_k == 1) win_spk = 0;
            if (spike_out === 1'b1) win_spk++;
            if (m_k == W) begin
               chk("win_spike_count", 32'(win_spk), 32'(m_r));
               win_cnt++;
            end
         end
      end
      rst      = r_v;
      in_valid = v_v;
      in_rate  = RW'(rate_v);
      #1;
      exp_rdy = !r_v && ((m_k == 0) || (m_k == W));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (r_v) begin
         m_k = 0;
      end else if (v_v && exp_rdy) begin
         m_k   = 1;
         m_r   = min_int(rate_v, W);
         m_sat = (rate_v > W);
      end else if (m_k == W) begin
         m_k = 0;
      end else if (m_k != 0) begin
         m_k++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
   endtask

   initial begin
      int guard;
      int base;

      rst      = 1'b1;
      in_valid = 1'b0;
      in_rate  = '0;

      // reset: outputs unknown before the first edge, checked from then on
      step(1'b1, 1'b0, 0, 1'b0);
      step(1'b1, 1'b0, 0);
      idle(2);

      // R=4 then idle: spikes at k=4,8,12,16, window returns to IDLE
      step(1'b0, 1'b1, 4);
      idle(20);

      // R=0, R=16, R=1
      step(1'b0, 1'b1, 0);
      idle(17);
      step(1'b0, 1'b1, 16);
      idle(17);
      step(1'b0, 1'b1, 1);
      idle(17);

      // saturating rate
      step(1'b0, 1'b1, 25);
      idle(17);

      // back-to-back: R=3 then R=5 chained at k=16
      step(1'b0, 1'b1, 3);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 5);
      idle(18);

      // reset at k=7 of an R=8 window, then R=2
      step(1'b0, 1'b1, 8);
      guard = 0;
      while (m_k != 7 && guard < 40) begin
         step(1'b0, 1'b0, 0);
         guard++;
      end
      chk("reach_k7", 32'(m_k), 32'd7);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b1, 3);
      step(1'b0, 1'b1, 2);
      idle(18);

      // random traffic over 1000 windows
      base  = win_cnt;
      guard = 0;
      while ((win_cnt - base) < 1000 && guard < 60000) begin
         step($urandom_range(0, 799) == 0,
              $urandom_range(0, 3) != 0,
              int'($urandom_range(0, 31)));
         guard++;
      end
      chk("rand_windows_done", 32'((win_cnt - base) >= 1000), 32'd1);
      idle(18);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
